// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the 128x32 single-port data SRAM.
// Every output is a register, and only one SRAM access is in flight at a time.
module dmem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [6:0]  p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ready,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [6:0]  p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ready,
    output logic [31:0] p1_rdata,
    output logic        CEN,
    output logic        WEN,
    output logic        OEN,
    output logic [6:0]  A,
    output logic [31:0] Data2Mem,
    input  logic [31:0] ReadDataMem
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [1:0] CNT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    state_t      state, state_d;
    logic        last_grant, last_d;
    logic        we_r, we_d;
    logic [1:0]  cnt, cnt_d;
    logic        cen_d, wen_d, oen_d;
    logic [6:0]  a_d;
    logic [31:0] wdata_d, rd0_d, rd1_d;
    logic        done, sel, sel_we;

    always_comb begin
        state_d = state;
        last_d  = last_grant;
        we_d    = we_r;
        cnt_d   = cnt;
        cen_d   = CEN;
        wen_d   = WEN;
        oen_d   = OEN;
        a_d     = A;
        wdata_d = Data2Mem;
        rd0_d   = p0_rdata;
        rd1_d   = p1_rdata;
        done    = 1'b0;
        sel     = 1'b0;
        sel_we  = 1'b0;
        case (state)
            IDLE: begin
                cen_d = 1'b1;
                wen_d = 1'b1;
                oen_d = 1'b1;
                if (p0_req || p1_req) begin
                    // A tie goes to the port that did not win last time.
                    sel     = (p0_req && p1_req) ? ~last_grant : p1_req;
                    sel_we  = sel ? p1_we : p0_we;
                    last_d  = sel;
                    we_d    = sel_we;
                    a_d     = sel ? p1_addr : p0_addr;
                    wdata_d = sel ? p1_wdata : p0_wdata;
                    cen_d   = 1'b0;
                    wen_d   = ~sel_we;
                    oen_d   = sel_we;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cen_d = 1'b1;
                if (we_r) begin
                    wen_d = 1'b1;
                    done  = 1'b1;
                end else if (RD_LAT == 0) begin
                    done = 1'b1;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 2'd0) done = 1'b1;
                else             cnt_d = cnt - 2'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Completion: read data is captured on the same edge that enters RESP.
        if (done) begin
            state_d = RESP;
            oen_d   = 1'b1;
            if (!we_r) begin
                if (last_grant) rd1_d = ReadDataMem;
                else            rd0_d = ReadDataMem;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            we_r       <= 1'b0;
            cnt        <= 2'd0;
            CEN        <= 1'b1;
            WEN        <= 1'b1;
            OEN        <= 1'b1;
            A          <= 7'd0;
            Data2Mem   <= 32'd0;
            p0_ready   <= 1'b0;
            p1_ready   <= 1'b0;
            p0_rdata   <= 32'd0;
            p1_rdata   <= 32'd0;
        end else begin
            state      <= state_d;
            last_grant <= last_d;
            we_r       <= we_d;
            cnt        <= cnt_d;
            CEN        <= cen_d;
            WEN        <= wen_d;
            OEN        <= oen_d;
            A          <= a_d;
            Data2Mem   <= wdata_d;
            p0_ready   <= done & ~last_grant;
            p1_ready   <= done & last_grant;
            p0_rdata   <= rd0_d;
            p1_rdata   <= rd1_d;
        end
    end
endmodule
